// File: rtl/odd_pipe_pkg.sv
// rtl/odd_pipe_pkg.sv - shared constants, scoreboard slot type and FSM states for the odd-pipe issue logic
package odd_pipe_pkg;

  localparam int NUM_SLOTS = 7;
  localparam int REG_AW    = 7;
  localparam int LAT_W     = 4;
  localparam int MAX_LAT   = 7;
  localparam int SB_LAT_W  = 3;

  localparam logic [2:0] UNIT_PERM = 3'b101;
  localparam logic [2:0] UNIT_LS   = 3'b110;
  localparam logic [2:0] UNIT_BR   = 3'b111;

  typedef struct packed {
    logic                valid;
    logic [REG_AW-1:0]   dst;
    logic                reg_wr;
    logic [SB_LAT_W-1:0] lat;
  } sb_slot_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } iss_state_t;

  // A result can never be later than the last tracked stage.
  function automatic logic [SB_LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
    if (lat > LAT_W'(MAX_LAT)) return SB_LAT_W'(MAX_LAT);
    return lat[SB_LAT_W-1:0];
  endfunction

endpackage

// File: rtl/odd_scoreboard.sv
// rtl/odd_scoreboard.sv - in-flight shift chain for the odd pipe plus 3-source RAW compare
module odd_scoreboard
  import odd_pipe_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  sb_slot_t               push_slot,
  input  logic [2:0][REG_AW-1:0] src_addr,
  input  logic [2:0]             src_use,
  output logic                   raw_hazard
);

  sb_slot_t slots [NUM_SLOTS];

  // slots[0] is pipe stage 1; entries shift one stage per cycle and are never killed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_SLOTS; k++) slots[k] <= '0;
    end else begin
      slots[0] <= push ? push_slot : '0;
      for (int k = 1; k < NUM_SLOTS; k++) slots[k] <= slots[k-1];
    end
  end

  always_comb begin
    raw_hazard = 1'b0;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (src_use[s] && slots[k].valid && slots[k].reg_wr &&
            slots[k].dst == src_addr[s] && int'(slots[k].lat) > k + 1)
          raw_hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/odd_issue_ctrl.sv
// rtl/odd_issue_ctrl.sv - single-entry hold/issue controller for the odd pipe
// Optional issue/stall counters enabled by ODD_ISSUE_STATS_EN.
module odd_issue_ctrl
  import odd_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [6:0]        dec_instr_id,
  input  logic [2:0]        dec_unit_id,
  input  logic [REG_AW-1:0] dec_reg_dst,
  input  logic              dec_reg_wr,
  input  logic [LAT_W-1:0]  dec_latency,
  input  logic [REG_AW-1:0] dec_ra_addr,
  input  logic [REG_AW-1:0] dec_rb_addr,
  input  logic [REG_AW-1:0] dec_rc_addr,
  input  logic [2:0]        dec_src_use,
  input  logic              flush,
  input  logic              ext_stall,
`ifdef ODD_ISSUE_STATS_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       issue_cnt,
`endif
  output logic              iss_valid,
  output logic [6:0]        iss_instr_id,
  output logic [2:0]        iss_unit_id,
  output logic [REG_AW-1:0] iss_reg_dst,
  output logic              iss_reg_wr,
  output logic [LAT_W-1:0]  iss_latency,
  output logic              hazard
);

  iss_state_t               state;
  logic [6:0]               h_instr_id;
  logic [2:0]               h_unit_id;
  logic [REG_AW-1:0]        h_reg_dst;
  logic                     h_reg_wr;
  logic [LAT_W-1:0]         h_latency;
  logic [2:0][REG_AW-1:0]   h_src_addr;
  logic [2:0]               h_src_use;
  logic                     held, sb_hazard, issue_now, accept;
  sb_slot_t                 push_slot;

  assign held      = (state == ST_HELD);
  assign hazard    = held && sb_hazard;
  assign issue_now = held && !sb_hazard && !ext_stall && !flush;
  assign dec_ready = !flush && (!held || issue_now);
  assign accept    = dec_valid && dec_ready;
  assign push_slot = '{valid: 1'b1, dst: h_reg_dst, reg_wr: h_reg_wr, lat: clamp_lat(h_latency)};

  odd_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (issue_now),
    .push_slot  (push_slot),
    .src_addr   (h_src_addr),
    .src_use    (h_src_use),
    .raw_hazard (sb_hazard)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_EMPTY;
      h_instr_id   <= '0;
      h_unit_id    <= '0;
      h_reg_dst    <= '0;
      h_reg_wr     <= 1'b0;
      h_latency    <= '0;
      h_src_addr   <= '0;
      h_src_use    <= '0;
      iss_valid    <= 1'b0;
      iss_instr_id <= '0;
      iss_unit_id  <= '0;
      iss_reg_dst  <= '0;
      iss_reg_wr   <= 1'b0;
      iss_latency  <= '0;
    end else begin
      iss_valid <= issue_now;
      if (issue_now) begin
        iss_instr_id <= h_instr_id;
        iss_unit_id  <= h_unit_id;
        iss_reg_dst  <= h_reg_dst;
        iss_reg_wr   <= h_reg_wr;
        iss_latency  <= h_latency;
      end
      if (accept) begin
        h_instr_id <= dec_instr_id;
        h_unit_id  <= dec_unit_id;
        h_reg_dst  <= dec_reg_dst;
        h_reg_wr   <= dec_reg_wr;
        h_latency  <= dec_latency;
        h_src_addr <= {dec_rc_addr, dec_rb_addr, dec_ra_addr};
        h_src_use  <= dec_src_use;
      end
      // flush blocks dec_ready, so a flushed cycle never accepts a new entry
      case (state)
        ST_EMPTY: if (accept) state <= ST_HELD;
        ST_HELD:  if (flush || (issue_now && !accept)) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

`ifdef ODD_ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (held && !issue_now && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (issue_now && issue_cnt != '1) issue_cnt <= issue_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_odd_issue_ctrl.sv
// tb/tb_odd_issue_ctrl.sv - table-driven bench for odd_issue_ctrl
module tb_odd_issue_ctrl;
  import odd_pipe_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              dec_valid, dec_ready;
  logic [6:0]        dec_instr_id;
  logic [2:0]        dec_unit_id;
  logic [REG_AW-1:0] dec_reg_dst, dec_ra_addr, dec_rb_addr, dec_rc_addr;
  logic              dec_reg_wr;
  logic [LAT_W-1:0]  dec_latency;
  logic [2:0]        dec_src_use;
  logic              flush, ext_stall;
  logic              iss_valid, iss_reg_wr, hazard;
  logic [6:0]        iss_instr_id;
  logic [2:0]        iss_unit_id;
  logic [REG_AW-1:0] iss_reg_dst;
  logic [LAT_W-1:0]  iss_latency;
`ifdef ODD_ISSUE_STATS_EN
  logic [31:0]       stall_cnt, issue_cnt;
`endif

  odd_issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_instr_id (dec_instr_id),
    .dec_unit_id  (dec_unit_id),
    .dec_reg_dst  (dec_reg_dst),
    .dec_reg_wr   (dec_reg_wr),
    .dec_latency  (dec_latency),
    .dec_ra_addr  (dec_ra_addr),
    .dec_rb_addr  (dec_rb_addr),
    .dec_rc_addr  (dec_rc_addr),
    .dec_src_use  (dec_src_use),
    .flush        (flush),
    .ext_stall    (ext_stall),
`ifdef ODD_ISSUE_STATS_EN
    .stall_cnt    (stall_cnt),
    .issue_cnt    (issue_cnt),
`endif
    .iss_valid    (iss_valid),
    .iss_instr_id (iss_instr_id),
    .iss_unit_id  (iss_unit_id),
    .iss_reg_dst  (iss_reg_dst),
    .iss_reg_wr   (iss_reg_wr),
    .iss_latency  (iss_latency),
    .hazard       (hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic [6:0] id;
    logic [2:0] unit;
    logic [6:0] dst;
    logic       wr;
    logic [3:0] lat;
    logic [6:0] ra, rb, rc;
    logic [2:0] src_use;
    logic       fl, st;
    logic       e_ready, e_haz, e_iv;
    logic [6:0] e_id;
  } vec_t;

  vec_t       tbl[$];
  int         n_pass = 0;
  int         n_total = 0;
  logic [6:0] exp_dst  [128];
  logic [3:0] exp_lat  [128];
  logic       exp_wr   [128];
  logic [2:0] exp_unit [128];

  function automatic vec_t mk(input logic dv, input logic [6:0] id, input logic [6:0] dst,
                              input logic wr, input logic [3:0] lat, input logic [6:0] ra,
                              input logic [6:0] rb, input logic [6:0] rc, input logic [2:0] su,
                              input logic fl, input logic st, input logic er, input logic eh,
                              input logic eiv, input logic [6:0] eid);
    vec_t v;
    v.dv = dv; v.id = id; v.unit = 3'(5 + (id % 3)); v.dst = dst; v.wr = wr; v.lat = lat;
    v.ra = ra; v.rb = rb; v.rc = rc; v.src_use = su; v.fl = fl; v.st = st;
    v.e_ready = er; v.e_haz = eh; v.e_iv = eiv; v.e_id = eid;
    return v;
  endfunction

  function automatic vec_t idle(input logic er, input logic eh, input logic eiv, input logic [6:0] eid);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, er, eh, eiv, eid);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t r);
    dec_valid = r.dv; dec_instr_id = r.id; dec_unit_id = r.unit; dec_reg_dst = r.dst;
    dec_reg_wr = r.wr; dec_latency = r.lat; dec_ra_addr = r.ra; dec_rb_addr = r.rb;
    dec_rc_addr = r.rc; dec_src_use = r.src_use; flush = r.fl; ext_stall = r.st;
    if (r.dv) begin
      exp_dst[r.id] = r.dst; exp_lat[r.id] = r.lat; exp_wr[r.id] = r.wr; exp_unit[r.id] = r.unit;
    end
  endtask

  task automatic apply(input vec_t r, input int idx);
    drive(r);
    @(negedge clk);
    check($sformatf("row%0d dec_ready", idx), 32'(dec_ready), 32'(r.e_ready));
    check($sformatf("row%0d hazard", idx), 32'(hazard), 32'(r.e_haz));
    check($sformatf("row%0d iss_valid", idx), 32'(iss_valid), 32'(r.e_iv));
    if (r.e_iv) begin
      check($sformatf("row%0d iss_instr_id", idx), 32'(iss_instr_id), 32'(r.e_id));
      check($sformatf("row%0d iss_reg_dst", idx), 32'(iss_reg_dst), 32'(exp_dst[r.e_id]));
      check($sformatf("row%0d iss_latency", idx), 32'(iss_latency), 32'(exp_lat[r.e_id]));
      check($sformatf("row%0d iss_reg_wr", idx), 32'(iss_reg_wr), 32'(exp_wr[r.e_id]));
      check($sformatf("row%0d iss_unit_id", idx), 32'(iss_unit_id), 32'(exp_unit[r.e_id]));
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " iss_valid"}, 32'(iss_valid), 0);
    check({tag, " iss_instr_id"}, 32'(iss_instr_id), 0);
    check({tag, " iss_unit_id"}, 32'(iss_unit_id), 0);
    check({tag, " iss_reg_dst"}, 32'(iss_reg_dst), 0);
    check({tag, " iss_reg_wr"}, 32'(iss_reg_wr), 0);
    check({tag, " iss_latency"}, 32'(iss_latency), 0);
    check({tag, " hazard"}, 32'(hazard), 0);
    check({tag, " dec_ready"}, 32'(dec_ready), 1);
  endtask

  initial begin
    rst = 1'b0;
    drive(idle(0, 0, 0, 0));
    @(posedge clk); @(posedge clk); #1;
    check_reset_state("reset");
    rst = 1'b1;

    // independent back-to-back stream
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 7'(1 + i), 7'(20 + i), 1, 2, 50, 0, 0, 3'b001, 0, 0,
                       1, 0, (i >= 2), 7'(i - 1)));
    tbl.push_back(idle(1, 0, 1, 4));
    tbl.push_back(idle(1, 0, 1, 5));
    tbl.push_back(idle(1, 0, 0, 0));
    // perm RAW: r10, L=4
    tbl.push_back(mk(1, 10, 10, 1, 4, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 11, 41, 1, 2, 10, 0, 0, 3'b001, 0, 0, 1, 0, 0, 0));
    tbl.push_back(idle(0, 1, 1, 10));
    tbl.push_back(idle(0, 1, 0, 0));
    tbl.push_back(idle(0, 1, 0, 0));
    tbl.push_back(idle(1, 0, 0, 0));
    tbl.push_back(idle(1, 0, 1, 11));
    // load RAW on rc: r5, L=6
    tbl.push_back(mk(1, 20, 5, 1, 6, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 21, 42, 1, 2, 0, 0, 5, 3'b100, 0, 0, 1, 0, 0, 0));
    tbl.push_back(idle(0, 1, 1, 20));
    for (int i = 0; i < 4; i++) tbl.push_back(idle(0, 1, 0, 0));
    tbl.push_back(idle(1, 0, 0, 0));
    tbl.push_back(idle(1, 0, 1, 21));
    // same consumer with no sources used
    tbl.push_back(mk(1, 22, 5, 1, 6, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 23, 43, 1, 2, 0, 0, 5, 3'b000, 0, 0, 1, 0, 0, 0));
    tbl.push_back(idle(1, 0, 1, 22));
    tbl.push_back(idle(1, 0, 1, 23));
    // latency 0 producer
    tbl.push_back(mk(1, 24, 9, 1, 0, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 25, 44, 1, 2, 9, 0, 0, 3'b001, 0, 0, 1, 0, 0, 0));
    tbl.push_back(idle(1, 0, 1, 24));
    tbl.push_back(idle(1, 0, 1, 25));
    // latency 15 clamps to 7: six stall cycles on rb
    tbl.push_back(mk(1, 26, 12, 1, 15, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 27, 45, 1, 2, 0, 12, 0, 3'b010, 0, 0, 1, 0, 0, 0));
    tbl.push_back(idle(0, 1, 1, 26));
    for (int i = 0; i < 5; i++) tbl.push_back(idle(0, 1, 0, 0));
    tbl.push_back(idle(1, 0, 0, 0));
    tbl.push_back(idle(1, 0, 1, 27));
    // store producer never blocks
    tbl.push_back(mk(1, 30, 7, 0, 4, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 31, 46, 1, 2, 7, 0, 0, 3'b001, 0, 0, 1, 0, 0, 0));
    tbl.push_back(idle(1, 0, 1, 30));
    tbl.push_back(idle(1, 0, 1, 31));
    // external stall keeps the held instruction
    tbl.push_back(mk(1, 40, 47, 1, 2, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 41, 48, 1, 2, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0, 0));
    tbl.push_back(idle(1, 0, 0, 0));
    tbl.push_back(idle(1, 0, 1, 40));
    // flush while held with dec_valid; r10 producer still tracked
    tbl.push_back(mk(1, 50, 10, 1, 4, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 51, 60, 1, 2, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 52, 61, 1, 2, 0, 0, 0, 3'b000, 1, 0, 0, 0, 1, 50));
    tbl.push_back(mk(1, 53, 62, 1, 2, 10, 0, 0, 3'b001, 0, 0, 1, 0, 0, 0));
    tbl.push_back(idle(0, 1, 0, 0));
    tbl.push_back(idle(1, 0, 0, 0));
    tbl.push_back(idle(1, 0, 1, 53));
    tbl.push_back(idle(1, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i], i);

    // reset in the middle of a RAW stall
    apply(mk(1, 70, 10, 1, 6, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0), 900);
    apply(mk(1, 71, 63, 1, 2, 10, 0, 0, 3'b001, 0, 0, 1, 0, 0, 0), 901);
    apply(idle(0, 1, 1, 70), 902);
    apply(idle(0, 1, 0, 0), 903);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midreset");
    @(posedge clk); #1;
    apply(mk(1, 72, 64, 1, 2, 10, 0, 0, 3'b001, 0, 0, 1, 0, 0, 0), 904);
    apply(idle(1, 0, 0, 0), 905);
    apply(idle(1, 0, 1, 72), 906);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/odd_issue_ctrl.md
Name: odd_issue_ctrl

Overview:
Issue controller in front of the odd pipe (permute / load-store / branch units). It takes one decoded instruction at a time from ID into a single-entry hold register. It tracks the odd-pipe instructions in flight in a 7-slot scoreboard. An instruction issues to the odd pipe only when no in-flight producer leaves one of its source registers unforwardable, and RAW-hazard stalls back-pressure decode.

Parameters:
NUM_SLOTS, 7, in-flight tracking depth; equals the odd-pipe stage count.
REG_AW, 7, register address width (128-entry RF).
LAT_W, 4, latency field width.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
dec_valid  in  1  decode presents an instruction
dec_ready  out  1  controller accepts this cycle
dec_instr_id  in  7  instruction ID
dec_unit_id  in  3  101 perm, 110 LS, 111 branch
dec_reg_dst  in  REG_AW  destination register
dec_reg_wr  in  1  instruction writes RF
dec_latency  in  LAT_W  result-ready stage
dec_ra_addr / dec_rb_addr / dec_rc_addr  in  REG_AW each  source registers
dec_src_use  in  3  [0]=ra, [1]=rb, [2]=rc used
flush  in  1  branch-mispredict kill
ext_stall  in  1  stall from even pipe / global
iss_valid  out  1  registered issue strobe to odd pipe
iss_instr_id / iss_unit_id / iss_reg_dst / iss_reg_wr / iss_latency  out  7/3/REG_AW/1/LAT_W  registered issued fields
hazard  out  1  combinational: held instruction blocked by RAW

Behaviour:
- Reset (rst=0 at clk edge): hold register empty, all slots invalid, iss_* = 0, FSM = EMPTY.
- The FSM has two states. EMPTY means nothing is held. HELD means a valid instruction is waiting.
- issue_now = HELD & !hazard & !ext_stall & !flush.
- dec_ready = !flush & (EMPTY | issue_now). This is combinational, so back-to-back issue reaches 1 per cycle.
- Accept when dec_valid & dec_ready, and load the hold register.
- Transitions:
  - EMPTY goes to HELD on accept.
  - HELD stays HELD on issue_now with accept.
  - HELD goes to EMPTY on issue_now without accept.
  - HELD goes to EMPTY on flush.
- Scoreboard:
  - On issue_now, slot1 is loaded with {1, reg_dst, reg_wr, clamp(latency, 7)}; otherwise slot1 is invalid.
  - slot k+1 <= slot k every cycle. Slot 7 falls off.
  - Slots are never flushed, because those instructions are already in the pipe.
- hazard = OR over used sources s and slots k=1..7 of (slot_k.valid & slot_k.reg_wr & slot_k.dst==s & slot_k.lat > k).
  - A producer with latency L unblocks its consumer L cycles after its own issue_now.
  - Latency 0 never causes a hazard.
- Outputs:
  - iss_valid <= issue_now; iss_* fields <= hold fields when issue_now, else hold previous values.
  - Latency is therefore 1 cycle from issue_now to the odd pipe seeing the instruction.
- A store (reg_wr=0) never creates a hazard. Register 0 is not special.
- Flush in the same cycle as dec_valid: the instruction is not accepted, and iss_valid is 0 next cycle.
- ext_stall holds the instruction without losing it; the scoreboard keeps draining.

Optional Feature:
ODD_ISSUE_STATS_EN
- Defined: adds outputs stall_cnt[31:0] and issue_cnt[31:0].
  - stall_cnt increments on each cycle with HELD & !issue_now & !flush.
  - issue_cnt increments on each issue_now.
  - Both saturate at all-ones and are cleared by reset.
- Undefined: the ports and counters are absent, with no behavioural difference otherwise.

Decomposition:
- Package odd_pipe_pkg holds:
  - unit-ID constants (PERM=101, LS=110, BR=111);
  - NUM_SLOTS and MAX_LAT=7;
  - the scoreboard slot typedef {valid, dst, reg_wr, lat}.
- Sub-module odd_scoreboard contains the slot shift chain plus the 3-source hazard compare. The top level keeps the FSM, hold register and issue registers.

Test Plan:
- Independent stream: 5 back-to-back instructions with dec_valid held high → dec_ready stays 1, and iss_valid is high for 5 consecutive cycles starting 1 cycle later.
- RAW on perm: producer dst=r10, L=4, then consumer ra=r10 next cycle → hazard=1 for 3 cycles, and the consumer's issue_now comes 4 cycles after the producer's.
- Load: producer dst=r5, L=6, consumer using rc=r5 with dec_src_use=100 → 5 stall cycles. The same consumer with dec_src_use=000 → no stall.
- Store producer with reg_wr=0 writing r7, then consumer ra=r7 → no stall.
- Flush while HELD with dec_valid=1 → next cycle EMPTY, no iss_valid, instruction dropped; a later r10 hazard is still honoured by the slots.
- Reset mid-stall (rst=0 for 1 cycle while HELD with slots valid) → all iss_* = 0, hazard=0, dec_ready=1 after reset.
